// File: rtl/intcode_pkg.sv
// intcode_pkg: shared state encoding and engine memory map for the noun/verb search.
// No ports; imported by intcode_nv_search and intcode_nv_counter.
package intcode_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ENG_RST,
    POKE_N,
    POKE_V,
    RUN,
    CHECK,
    DONE
  } nv_state_t;

  localparam int unsigned ADDR_RESULT = 0;
  localparam int unsigned ADDR_NOUN   = 1;
  localparam int unsigned ADDR_VERB   = 2;

endpackage

// File: rtl/intcode_nv_counter.sv
// intcode_nv_counter: noun/verb candidate counter, verb inner loop, noun outer loop.
// Ports: clk, reset (async low), clear, advance -> noun, verb, last (at NOUN_MAX,VERB_MAX).
module intcode_nv_counter
  import intcode_pkg::*;
#(
  parameter int unsigned NOUN_MAX = 99,
  parameter int unsigned VERB_MAX = 99,
  parameter int unsigned NW = $clog2(NOUN_MAX + 1),
  parameter int unsigned VW = $clog2(VERB_MAX + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  input  logic          advance,
  output logic [NW-1:0] noun,
  output logic [VW-1:0] verb,
  output logic          last
);

  logic verb_wrap;

  assign verb_wrap = (verb == VW'(VERB_MAX));
  assign last = verb_wrap && (noun == NW'(NOUN_MAX));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      noun <= '0;
      verb <= '0;
    end else if (clear) begin
      noun <= '0;
      verb <= '0;
    end else if (advance) begin
      if (verb_wrap) begin
        verb <= '0;
        noun <= noun + 1'b1;
      end else begin
        verb <= verb + 1'b1;
      end
    end
  end

endmodule

// File: rtl/intcode_nv_search.sv
// intcode_nv_search: drives one intcode engine through an exhaustive noun/verb sweep.
// Ports: host side clk/reset(async low)/start/target -> busy/done/found/noun/verb/answer/
//   iterations/timeout_seen; engine side intc_reset/intc_write_program/intc_addr/
//   intc_wdata/intc_run_program <- intc_halt/intc_data.
// Optional: define INTCODE_SEARCH_TIMEOUT_EN to bound RUN to RUN_TIMEOUT cycles.
module intcode_nv_search
  import intcode_pkg::*;
#(
  parameter int unsigned DATA_W      = 64,
  parameter int unsigned NOUN_MAX    = 99,
  parameter int unsigned VERB_MAX    = 99,
  parameter int unsigned RUN_TIMEOUT = 100000
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic [DATA_W-1:0]             target,
  output logic                          busy,
  output logic                          done,
  output logic                          found,
  output logic [$clog2(NOUN_MAX+1)-1:0] noun,
  output logic [$clog2(VERB_MAX+1)-1:0] verb,
  output logic [15:0]                   answer,
  output logic [15:0]                   iterations,
  output logic                          timeout_seen,
  output logic                          intc_reset,
  output logic                          intc_write_program,
  output logic [DATA_W-1:0]             intc_addr,
  output logic [DATA_W-1:0]             intc_wdata,
  output logic                          intc_run_program,
  input  logic                          intc_halt,
  input  logic [DATA_W-1:0]             intc_data
);

  nv_state_t state, state_nx;
  logic      accept;
  logic      cnt_clr;
  logic      cnt_adv;
  logic      last;
  logic      hit;
  logic      run_to;
  logic      to_flag;

  intcode_nv_counter #(
    .NOUN_MAX(NOUN_MAX),
    .VERB_MAX(VERB_MAX)
  ) u_cnt (
    .clk    (clk),
    .reset  (reset),
    .clear  (cnt_clr),
    .advance(cnt_adv),
    .noun   (noun),
    .verb   (verb),
    .last   (last)
  );

  assign accept = start && (state == IDLE || state == DONE);

`ifdef INTCODE_SEARCH_TIMEOUT_EN
  localparam int unsigned TW = $clog2(RUN_TIMEOUT + 1);
  logic [TW-1:0] to_cnt;

  assign run_to = (state == RUN) && !intc_halt && (to_cnt == '0);

  // to_flag marks a candidate abandoned by the timeout so CHECK
  // treats it as a miss without looking at intc_data.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      to_cnt       <= '0;
      to_flag      <= 1'b0;
      timeout_seen <= 1'b0;
    end else begin
      if (state == POKE_V)
        to_cnt <= TW'(RUN_TIMEOUT - 1);
      else if (state == RUN && to_cnt != '0)
        to_cnt <= to_cnt - 1'b1;
      if (state == RUN)
        to_flag <= run_to;
      if (accept)
        timeout_seen <= 1'b0;
      else if (run_to)
        timeout_seen <= 1'b1;
    end
  end
`else
  assign run_to       = 1'b0;
  assign to_flag      = 1'b0;
  assign timeout_seen = 1'b0;
`endif

  assign hit = !to_flag && (intc_data == target);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    cnt_clr  = 1'b0;
    cnt_adv  = 1'b0;
    unique case (state)
      IDLE, DONE: begin
        if (start) begin
          state_nx = ENG_RST;
          cnt_clr  = 1'b1;
        end
      end
      ENG_RST: state_nx = POKE_N;
      POKE_N:  state_nx = POKE_V;
      POKE_V:  state_nx = RUN;
      RUN: begin
        if (intc_halt || run_to) state_nx = CHECK;
      end
      CHECK: begin
        if (hit || last) begin
          state_nx = DONE;
        end else begin
          state_nx = ENG_RST;
          cnt_adv  = 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Outputs are registered off the next state so each strobe lines up
  // with the state it belongs to.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy               <= 1'b0;
      done               <= 1'b0;
      found              <= 1'b0;
      answer             <= '0;
      iterations         <= '0;
      intc_reset         <= 1'b1;
      intc_write_program <= 1'b0;
      intc_addr          <= '0;
      intc_wdata         <= '0;
      intc_run_program   <= 1'b0;
    end else begin
      busy               <= !(state_nx inside {IDLE, DONE});
      intc_reset         <= (state_nx == ENG_RST);
      intc_write_program <= (state_nx == POKE_N) || (state_nx == POKE_V);
      intc_run_program   <= (state_nx == RUN);
      intc_addr          <= '0;
      intc_wdata         <= '0;
      if (state_nx == POKE_N) begin
        intc_addr  <= DATA_W'(ADDR_NOUN);
        intc_wdata <= DATA_W'(noun);
      end else if (state_nx == POKE_V) begin
        intc_addr  <= DATA_W'(ADDR_VERB);
        intc_wdata <= DATA_W'(verb);
      end
      if (accept) begin
        done       <= 1'b0;
        found      <= 1'b0;
        answer     <= '0;
        iterations <= '0;
      end else if (state == CHECK) begin
        iterations <= iterations + 16'd1;
        if (hit) begin
          found  <= 1'b1;
          answer <= 16'(noun) * 16'd100 + 16'(verb);
        end
        if (hit || last) done <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_intcode_nv_search.sv
// tb_intcode_nv_search: self-checking bench for intcode_nv_search with a behavioural engine.
// Sweeps a 3x3 candidate space (NOUN_MAX=VERB_MAX=2).
module tb_intcode_nv_search;

  localparam int DW   = 64;
  localparam int NMAX = 2;
  localparam int VMAX = 2;
  localparam int RTO  = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic [DW-1:0] target = '0;
  logic          busy, done, found, timeout_seen;
  logic [1:0]    noun, verb;
  logic [15:0]   answer, iterations;
  logic          intc_reset, intc_write_program, intc_run_program;
  logic [DW-1:0] intc_addr, intc_wdata, intc_data;
  logic          intc_halt;

  always #5 clk = ~clk;

  intcode_nv_search #(
    .DATA_W(DW), .NOUN_MAX(NMAX), .VERB_MAX(VMAX), .RUN_TIMEOUT(RTO)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .target(target),
    .busy(busy), .done(done), .found(found), .noun(noun), .verb(verb),
    .answer(answer), .iterations(iterations), .timeout_seen(timeout_seen),
    .intc_reset(intc_reset), .intc_write_program(intc_write_program),
    .intc_addr(intc_addr), .intc_wdata(intc_wdata),
    .intc_run_program(intc_run_program), .intc_halt(intc_halt),
    .intc_data(intc_data)
  );

  // Behavioural engine: word 0 = tbl[noun][verb], halts halt_delay
  // run cycles after start, or never for the hang candidate.
  logic [DW-1:0] tbl [4][4];
  logic [DW-1:0] m_noun = '0;
  logic [DW-1:0] m_verb = '0;
  logic          halted = 1'b0;
  int            run_cnt = 0;
  int            halt_delay = 3;
  bit            hang_en = 1'b0;
  int            hang_n = 1;
  int            hang_v = 1;

  always @(posedge clk) begin
    if (intc_reset) begin
      halted  <= 1'b0;
      run_cnt <= 0;
    end else begin
      if (intc_write_program) begin
        if (intc_addr == 1) m_noun <= intc_wdata;
        else if (intc_addr == 2) m_verb <= intc_wdata;
      end
      if (intc_run_program && !halted &&
          !(hang_en && m_noun == DW'(hang_n) && m_verb == DW'(hang_v))) begin
        if (run_cnt + 1 >= halt_delay) halted <= 1'b1;
        run_cnt <= run_cnt + 1;
      end
    end
  end

  assign intc_halt = halted;
  assign intc_data = halted ? tbl[m_noun[1:0]][m_verb[1:0]] : '1;

  bit counting = 1'b0;
  int rst_cyc = 0;
  always @(posedge clk) begin
    if (!counting) rst_cyc <= 0;
    else if (intc_reset) rst_cyc <= rst_cyc + 1;
  end

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fill_default();
    for (int n = 0; n < 4; n++)
      for (int v = 0; v < 4; v++)
        tbl[n][v] = DW'(10 * n + v);
  endtask

  task automatic wait_done();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      if (done) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk("done_reached", 64'(seen), 64'd1);
  endtask

  task automatic sweep(input logic [DW-1:0] tgt);
    target = tgt;
    @(negedge clk);
    counting = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("start_latency", {61'd0, busy, intc_reset, done}, 64'b110);
    wait_done();
    counting = 1'b0;
  endtask

  typedef struct {
    logic [DW-1:0] tgt;
    logic          found;
    int            noun;
    int            verb;
    int            answer;
    int            iter;
  } vec_t;

  vec_t vt[5];

  initial begin
    vt[0] = '{64'd21, 1'b1, 2, 1, 201, 8};
    vt[1] = '{64'd0,  1'b1, 0, 0, 0,   1};
    vt[2] = '{64'd99, 1'b0, 2, 2, 0,   9};
    vt[3] = '{64'd2,  1'b1, 0, 2, 2,   3};
    vt[4] = '{64'h8000_0000_0000_0015, 1'b0, 2, 2, 0, 9};
    fill_default();

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_intc_reset", 64'(intc_reset), 64'd1);
    chk("rst_flags", {56'd0, busy, done, found, timeout_seen,
        intc_write_program, intc_run_program, 2'd0}, 64'd0);
    chk("rst_nv", {60'd0, noun, verb}, 64'd0);
    chk("rst_counts", {32'd0, answer, iterations}, 64'd0);
    chk("rst_addr", intc_addr | intc_wdata, 64'd0);
    reset = 1'b1;
    @(negedge clk);
    chk("rel_intc_reset", 64'(intc_reset), 64'd0);

    // Table-driven directed sweeps
    for (int k = 0; k < 5; k++) begin
      sweep(vt[k].tgt);
      chk($sformatf("v%0d_found", k), 64'(found), 64'(vt[k].found));
      chk($sformatf("v%0d_noun", k), 64'(noun), 64'(vt[k].noun));
      chk($sformatf("v%0d_verb", k), 64'(verb), 64'(vt[k].verb));
      chk($sformatf("v%0d_answer", k), 64'(answer), 64'(vt[k].answer));
      chk($sformatf("v%0d_iter", k), 64'(iterations), 64'(vt[k].iter));
      chk($sformatf("v%0d_rstpulses", k), 64'(rst_cyc), 64'(vt[k].iter));
      chk($sformatf("v%0d_busy_to", k), {62'd0, busy, timeout_seen}, 64'd0);
    end

    // Reset asserted mid-RUN of candidate (1,0)
    begin
      bit hitrun;
      target = 64'd21;
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      hitrun = 1'b0;
      for (int i = 0; i < 500; i++) begin
        if (intc_run_program && noun == 2'd1 && verb == 2'd0) begin
          hitrun = 1'b1;
          break;
        end
        @(negedge clk);
      end
      chk("midrun_reached", 64'(hitrun), 64'd1);
      #2 reset = 1'b0;
      #1;
      chk("midrun_flags", {59'd0, busy, done, found, intc_run_program, intc_write_program}, 64'd0);
      chk("midrun_state", {44'd0, iterations, noun, verb}, 64'd0);
      chk("midrun_intc_reset", 64'(intc_reset), 64'd1);
      repeat (2) @(negedge clk);
      chk("midrun_hold", {62'd0, intc_reset, busy}, 64'b10);
      reset = 1'b1;
      sweep(64'd21);
      chk("after_rst_answer", 64'(answer), 64'd201);
      chk("after_rst_iter", 64'(iterations), 64'd8);
    end

    // Start pulsed during a sweep is ignored
    target = 64'd21;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (15) @(negedge clk);
    start = 1'b1;
    @(negedge clk); start = 1'b0;
    wait_done();
    chk("ign_answer", 64'(answer), 64'd201);
    chk("ign_iter", 64'(iterations), 64'd8);
    sweep(64'd2);
    chk("restart_answer", 64'(answer), 64'd2);
    chk("restart_iter", 64'(iterations), 64'd3);

`ifdef INTCODE_SEARCH_TIMEOUT_EN
    hang_en = 1'b1;
    hang_n = 1;
    hang_v = 1;
    sweep(64'd12);
    chk("to_seen", 64'(timeout_seen), 64'd1);
    chk("to_found", 64'(found), 64'd1);
    chk("to_answer", 64'(answer), 64'd102);
    chk("to_iter", 64'(iterations), 64'd6);
    hang_en = 1'b0;
    sweep(64'd21);
    chk("to_cleared", 64'(timeout_seen), 64'd0);
`endif

    // Randomised sweeps against a first-match reference scan
    for (int r = 0; r < 40; r++) begin
      logic [DW-1:0] tgt;
      bit ef;
      int en, ev, ei;
      for (int n = 0; n < 4; n++)
        for (int v = 0; v < 4; v++)
          tbl[n][v] = DW'($urandom_range(0, 11));
      tgt = DW'($urandom_range(0, 12));
      halt_delay = $urandom_range(1, 5);
      ef = 1'b0; en = NMAX; ev = VMAX; ei = 0;
      for (int n = 0; n <= NMAX; n++)
        for (int v = 0; v <= VMAX; v++)
          if (!ef) begin
            ei++;
            if (tbl[n][v] == tgt) begin
              ef = 1'b1; en = n; ev = v;
            end
          end
      sweep(tgt);
      chk($sformatf("r%0d_found", r), 64'(found), 64'(ef));
      chk($sformatf("r%0d_nv", r), {60'd0, noun, verb}, 64'(en * 4 + ev));
      chk($sformatf("r%0d_answer", r), 64'(answer), ef ? 64'(100 * en + ev) : 64'd0);
      chk($sformatf("r%0d_iter", r), 64'(iterations), 64'(ei));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
